// File: rtl/commit_trace_sequencer_if.sv
// Bundle of commit-side inputs and trace-side outputs for the commit trace sequencer.
// The slave modport is the sequencer's view; master is the commit stage / trace consumer view.
interface commit_trace_sequencer_if;
  logic        in0_valid;
  logic [31:0] in0_pc;
  logic [3:0]  in0_wen;
  logic [4:0]  in0_wnum;
  logic [31:0] in0_wdata;

  logic        in1_valid;
  logic [31:0] in1_pc;
  logic [3:0]  in1_wen;
  logic [4:0]  in1_wnum;
  logic [31:0] in1_wdata;

  logic        out_ready;
  logic        commit_stall;

  logic        debug_wb_valid;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] trace_cnt;
  logic        overflow;

  modport slave (
    input  in0_valid, in0_pc, in0_wen, in0_wnum, in0_wdata,
    input  in1_valid, in1_pc, in1_wen, in1_wnum, in1_wdata,
    input  out_ready,
    output commit_stall,
    output debug_wb_valid, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output trace_cnt, overflow
  );

  modport master (
    output in0_valid, in0_pc, in0_wen, in0_wnum, in0_wdata,
    output in1_valid, in1_pc, in1_wen, in1_wnum, in1_wdata,
    output out_ready,
    input  commit_stall,
    input  debug_wb_valid, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  trace_cnt, overflow
  );
endinterface

// File: rtl/commit_trace_sequencer.sv
// Serialises up to two committed-instruction records per cycle into a single-lane
// golden-trace stream, in program order, with commit back-pressure and overflow flag.
module commit_trace_sequencer #(
  parameter int DEPTH         = 8,
  parameter bit SKIP_NO_WRITE = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  commit_trace_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  rec_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  rec_t          out_q, out_d;
  logic          valid_q, valid_d;
  logic [31:0]   trace_cnt_q, trace_cnt_d;
  logic          overflow_q, overflow_d;

  logic          stall;
  logic          keep0, keep1;
  logic          pop;
  logic [1:0]    n_push;
  logic [AW-1:0] wa0, wa1;
  rec_t          rec0, rec1;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    stall       = (count_q >= STALL_AT);
    rec0        = '{pc: bus.in0_pc, wen: bus.in0_wen, wnum: bus.in0_wnum, wdata: bus.in0_wdata};
    rec1        = '{pc: bus.in1_pc, wen: bus.in1_wen, wnum: bus.in1_wnum, wdata: bus.in1_wdata};

    // Records arriving while stalled are dropped; they only raise the sticky overflow flag.
    keep0       = bus.in0_valid && !(SKIP_NO_WRITE && (bus.in0_wen == 4'b0)) && !stall;
    keep1       = bus.in1_valid && !(SKIP_NO_WRITE && (bus.in1_wen == 4'b0)) && !stall;
    n_push      = {1'b0, keep0} + {1'b0, keep1};

    wa0         = wr_ptr_q;
    wa1         = keep0 ? wr_ptr_q + AW'(1) : wr_ptr_q;
    wr_ptr_d    = wr_ptr_q + AW'(n_push);

    pop         = (count_q != '0) && bus.out_ready;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(n_push) - CW'(pop);

    valid_d     = pop;
    out_d       = pop ? mem[rd_ptr_q] : out_q;
    trace_cnt_d = trace_cnt_q + 32'(pop);
    overflow_d  = overflow_q | (stall & (bus.in0_valid | bus.in1_valid));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      trace_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      trace_cnt_q <= trace_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is left unreset; count/pointers guarantee no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (keep0) mem[wa0] <= rec0;
    if (keep1) mem[wa1] <= rec1;
  end

  assign bus.commit_stall      = stall;
  assign bus.debug_wb_valid    = valid_q;
  assign bus.debug_wb_pc       = out_q.pc;
  assign bus.debug_wb_rf_wen   = out_q.wen;
  assign bus.debug_wb_rf_wnum  = out_q.wnum;
  assign bus.debug_wb_rf_wdata = out_q.wdata;
  assign bus.trace_cnt         = trace_cnt_q;
  assign bus.overflow          = overflow_q;

endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Scoreboard bench for commit_trace_sequencer: a behavioural FIFO model predicts stall,
// emitted records, trace count and overflow, compared each cycle #1 after the rising edge.
module tb_commit_trace_sequencer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  commit_trace_sequencer_if bus ();

  commit_trace_sequencer #(.DEPTH(DEPTH), .SKIP_NO_WRITE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  rec_t        sb[$];
  int          mcnt;
  logic [31:0] tcnt;
  logic        ovf;
  rec_t        last;
  int          n_chk;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_full(input bit v0, input logic [31:0] pc0, input logic [3:0] wen0,
                          input logic [4:0] wn0, input logic [31:0] wd0,
                          input bit v1, input logic [31:0] pc1, input logic [3:0] wen1,
                          input logic [4:0] wn1, input logic [31:0] wd1);
    bus.in0_valid = v0; bus.in0_pc = pc0; bus.in0_wen = wen0; bus.in0_wnum = wn0; bus.in0_wdata = wd0;
    bus.in1_valid = v1; bus.in1_pc = pc1; bus.in1_wen = wen1; bus.in1_wnum = wn1; bus.in1_wdata = wd1;
  endtask

  task automatic set_in(input bit v0, input logic [31:0] pc0, input logic [3:0] wen0,
                        input bit v1, input logic [31:0] pc1, input logic [3:0] wen1);
    set_full(v0, pc0, wen0, pc0[6:2], ~pc0, v1, pc1, wen1, pc1[6:2], ~pc1);
  endtask

  task automatic clear_model();
    sb.delete();
    mcnt = 0;
    tcnt = '0;
    ovf  = 1'b0;
    last = '{pc: '0, wen: '0, wnum: '0, wdata: '0};
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input bit rdy);
    bit   stall_e;
    bit   pop_e;
    int   np;
    rec_t e;
    bus.out_ready = rdy;
    stall_e = (mcnt >= DEPTH - 1);
    pop_e   = (mcnt > 0) && rdy;
    np      = 0;
    check("commit_stall", bus.commit_stall, stall_e);
    if (stall_e) begin
      if (bus.in0_valid || bus.in1_valid) ovf = 1'b1;
    end else begin
      if (bus.in0_valid && bus.in0_wen != 4'b0) begin
        sb.push_back('{pc: bus.in0_pc, wen: bus.in0_wen, wnum: bus.in0_wnum, wdata: bus.in0_wdata});
        np++;
      end
      if (bus.in1_valid && bus.in1_wen != 4'b0) begin
        sb.push_back('{pc: bus.in1_pc, wen: bus.in1_wen, wnum: bus.in1_wnum, wdata: bus.in1_wdata});
        np++;
      end
    end
    mcnt = mcnt + np - (pop_e ? 1 : 0);
    if (pop_e) tcnt++;
    @(posedge clk);
    #1;
    check("wb_valid", bus.debug_wb_valid, pop_e);
    if (bus.debug_wb_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check("wb_pc", bus.debug_wb_pc, e.pc);
      check("wb_wen", bus.debug_wb_rf_wen, e.wen);
      check("wb_wnum", bus.debug_wb_rf_wnum, e.wnum);
      check("wb_wdata", bus.debug_wb_rf_wdata, e.wdata);
      last = e;
    end else if (!bus.debug_wb_valid) begin
      check("wb_pc_hold", bus.debug_wb_pc, last.pc);
      check("wb_wdata_hold", bus.debug_wb_rf_wdata, last.wdata);
    end
    check("trace_cnt", bus.trace_cnt, tcnt);
    check("overflow", bus.overflow, ovf);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    set_in(0, '0, '0, 0, '0, '0);
    repeat (n) step(rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.debug_wb_valid, 1'b0);
    check({tag, "_pc"}, bus.debug_wb_pc, 32'h0);
    check({tag, "_wen"}, bus.debug_wb_rf_wen, 4'h0);
    check({tag, "_wnum"}, bus.debug_wb_rf_wnum, 5'h0);
    check({tag, "_wdata"}, bus.debug_wb_rf_wdata, 32'h0);
    check({tag, "_cnt"}, bus.trace_cnt, 32'h0);
    check({tag, "_ovf"}, bus.overflow, 1'b0);
    check({tag, "_stall"}, bus.commit_stall, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    n_chk = 0;
    n_bad = 0;
    clear_model();

    // Reset with unknown inputs.
    reset = 1'b0;
    set_full(1'bx, 'x, 'x, 'x, 'x, 1'bx, 'x, 'x, 'x, 'x);
    bus.out_ready = 1'bx;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    idle(0, 1);
    set_in(0, '0, '0, 0, '0, '0);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Dual commit, consumer always ready.
    set_full(1, 32'hBFC0_0000, 4'hF, 5'd2, 32'h11, 1, 32'hBFC0_0004, 4'hF, 5'd3, 32'h22);
    step(1);
    idle(3, 1);
    check("dual_cnt", bus.trace_cnt, 32'd2);

    // No-write record on lane 0 is filtered.
    set_in(1, 32'h100, 4'h0, 1, 32'h104, 4'hF);
    step(1);
    idle(3, 1);
    check("skip_cnt", bus.trace_cnt, 32'd3);

    // Fill with consumer stalled, then poke while stalled, then drain.
    pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      set_in(1, pc, 4'hF, 1, pc + 4, 4'h3);
      step(0);
      pc += 8;
    end
    set_in(1, 32'hDEAD_0000, 4'hF, 0, '0, '0);
    step(0);
    idle(2, 0);
    idle(DEPTH + 2, 1);
    set_in(1, 32'h300, 4'h1, 0, '0, '0);
    step(1);
    idle(2, 1);

    // count == DEPTH-2, then two pushes and a pop in one cycle lands on DEPTH-1.
    pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      set_in(1, pc, 4'hF, 1, pc + 4, 4'hF);
      step(0);
      pc += 8;
    end
    set_in(1, pc, 4'hF, 1, pc + 4, 4'hF);
    step(1);
    idle(DEPTH + 2, 1);

    // Asynchronous reset in the middle of draining.
    pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      set_in(1, pc, 4'hF, 1, pc + 4, 4'hF);
      step(0);
      pc += 8;
    end
    idle(1, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    idle(4, 1);
    set_in(0, '0, '0, 1, 32'h600, 4'h8);
    step(1);
    idle(2, 1);

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1) == 1, pc, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
             $urandom_range(0, 1) == 1, pc + 4, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      step($urandom_range(0, 9) < 6);
      pc += 8;
    end
    idle(DEPTH + 2, 1);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/commit_trace_sequencer.md
Name: commit_trace_sequencer

Overview:
- Takes up to two committed-instruction debug records per cycle from the dual-commit stage (lane 0 is older than lane 1).
- Buffers them in program order in a small FIFO.
- Emits them one per cycle on the single-lane writeback trace port used by the golden-trace comparator.
- Back-pressures commit when the FIFO cannot absorb a full dual-commit cycle, and counts emitted records and overflow events.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- SKIP_NO_WRITE, 1, if 1, records with wen==4'b0 are discarded at input and never enter the FIFO.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- in0_valid  in  1  lane-0 committed record valid
- in0_pc  in  32  lane-0 PC
- in0_wen  in  4  lane-0 register-file byte write strobe
- in0_wnum  in  5  lane-0 architectural destination
- in0_wdata  in  32  lane-0 write data
- in1_valid, in1_pc, in1_wen, in1_wnum, in1_wdata  in  1/32/4/5/32  lane-1 record, same meaning as lane 0
- out_ready  in  1  trace consumer may accept a record this cycle
- commit_stall  out  1  commit must not present records this cycle
- debug_wb_valid  out  1  trace record valid, one-cycle pulse per record
- debug_wb_pc  out  32  emitted PC
- debug_wb_rf_wen  out  4  emitted strobe
- debug_wb_rf_wnum  out  5  emitted destination
- debug_wb_rf_wdata  out  32  emitted data
- trace_cnt  out  32  number of records emitted; wraps at 2^32
- overflow  out  1  sticky error flag

Behaviour:
- Reset (reset==0, asynchronous): FIFO pointers and count go to 0. All outputs go to 0, including debug_wb_*, trace_cnt and overflow. commit_stall comes out of reset at 0.
- Input qualification, per lane:
  - keep = inX_valid && !(SKIP_NO_WRITE && inX_wen==0).
  - Kept records are written in lane order: lane 0 at wr_ptr, lane 1 at wr_ptr+1 if lane 0 is kept, otherwise lane 1 at wr_ptr.
  - wr_ptr advances by the number of kept records (0/1/2) and wraps modulo DEPTH.
- Stall:
  - commit_stall = (count >= DEPTH-1). It is combinational from registered count only, so there is no path from in*_valid.
  - Any inX_valid while commit_stall==1 sets overflow, which stays 1 until reset. Those records are dropped and the FIFO is not modified.
- Output stage:
  - The output register loads when count>0 and out_ready==1 at the edge: the head entry goes to debug_wb_*, debug_wb_valid=1, rd_ptr+1, trace_cnt+1.
  - Otherwise debug_wb_valid=0 and the data fields hold their last values.
- Latency: a record accepted at edge E appears on debug_wb_* after edge E+1 at the earliest. There is no input-to-output bypass.
- Count update: count_next = count + pushes − pop, with pushes in 0..2 and pop in 0..1. Simultaneous push and pop in the same cycle is legal. Count width is log2(DEPTH)+1.
- Ordering: emission order strictly equals commit order (lane 0 before lane 1, earlier cycles first). No reordering and no duplication.
- Full/empty:
  - Pop is never performed at count==0.
  - Pushes are never performed while stalled, so count never exceeds DEPTH.
  - With count==DEPTH-2 and two pushes plus one pop in the same cycle, count becomes DEPTH-1 and stall asserts next cycle.
- Pipeline flush has no effect on this block. Records are architectural once committed, so there is no flush port.

Test Plan:
- Reset with X on inputs, then release → all outputs 0, commit_stall=0, trace_cnt=0.
- Hold out_ready=1. One cycle with in0={pc 0xBFC00000, wen 0xF, wnum 2, wdata 0x11} and in1={pc 0xBFC00004, wen 0xF, wnum 3, wdata 0x22} → debug_wb_valid high on two consecutive cycles starting one edge later, pc 0xBFC00000 then 0xBFC00004. trace_cnt=2.
- SKIP_NO_WRITE=1: in0 wen=0 (pc 0x100) and in1 wen=0xF (pc 0x104) → only pc 0x104 is emitted; trace_cnt increments by 1.
- DEPTH=8, out_ready=0, two records per cycle → commit_stall asserts once count reaches 7. Raise out_ready → exactly the accepted records are emitted in order; stall deasserts when count ≤ 6.
- Drive in0_valid while commit_stall=1 → overflow=1 and stays 1. The dropped PC never appears at the output.
- Pull reset low while count=5 and debug_wb_valid is pulsing → immediate return to reset values, and after release nothing stale is emitted.
